// File: rtl/gcn_host_streamer.sv
// Host-side initiator for the GCN accelerator pin bus: streams weights and a sparse
// input list out over g_bus, then captures the returned header and result words.
module gcn_host_streamer #(
  parameter int WROWS     = 32,
  parameter int OUT_WORDS = 200,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  col_base,
  input  logic [7:0]  nnz,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        w_rd_en,
  output logic [5:0]  w_rd_addr,
  input  logic [15:0] w_rd_data,
  output logic        x_rd_en,
  output logic [7:0]  x_rd_addr,
  input  logic [31:0] x_rd_data,
  output logic        g_req,
  output logic        g_cmd,
  output logic [15:0] g_bus,
  input  logic        g_idle,
  input  logic        g_ostart,
  input  logic [15:0] g_bus_in,
  input  logic        g_rdy,
  output logic [15:0] hdr_col,
  output logic        r_wr_en,
  output logic [7:0]  r_wr_addr,
  output logic [15:0] r_wr_data
);
  localparam int WWORDS = 2 * WROWS;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_HDR, S_WGT, S_INA, S_INB, S_WOUT, S_CAP, S_WEND, S_DONE, S_ERR
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [6:0]  widx, widx_next;
  logic [7:0]  eidx, eidx_next;
  logic [7:0]  ridx, ridx_next;
  logic [7:0]  col_q, col_next;
  logic [7:0]  nnz_q, nnz_next;
  logic [15:0] data_q, data_next;
  logic [15:0] hdr_next;
  logic        reject;
  logic        busy_next, done_next, err_next;
  logic        w_rd_en_next, x_rd_en_next;
  logic [5:0]  w_rd_addr_next;
  logic [7:0]  x_rd_addr_next;
  logic        g_req_next, g_cmd_next;
  logic [15:0] g_bus_next;
  logic        r_wr_en_next;
  logic [7:0]  r_wr_addr_next;
  logic [15:0] r_wr_data_next;

  // Bus-side outputs lag the state by one cycle; RAM reads are issued one cycle
  // ahead so read data lines up with the state that forwards it.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt + 16'd1;
    widx_next      = widx;
    eidx_next      = eidx;
    ridx_next      = ridx;
    col_next       = col_q;
    nnz_next       = nnz_q;
    data_next      = data_q;
    hdr_next       = hdr_col;
    reject         = 1'b0;
    w_rd_en_next   = 1'b0;
    w_rd_addr_next = 6'd0;
    x_rd_en_next   = 1'b0;
    x_rd_addr_next = 8'd0;
    g_req_next     = 1'b0;
    g_cmd_next     = 1'b0;
    g_bus_next     = 16'd0;
    r_wr_en_next   = 1'b0;
    r_wr_addr_next = 8'd0;
    r_wr_data_next = 16'd0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (nnz == 8'd0) begin
            reject = 1'b1;
          end else if (g_idle) begin
            state_next = S_REQ;
            col_next   = col_base & 8'hFE;
            nnz_next   = nnz;
          end
        end
      end
      S_REQ: begin
        g_req_next     = 1'b1;
        state_next     = S_HDR;
        w_rd_en_next   = 1'b1;
        w_rd_addr_next = 6'd0;
      end
      S_HDR: begin
        g_bus_next     = {8'h00, col_q};
        state_next     = S_WGT;
        widx_next      = 7'd0;
        w_rd_en_next   = 1'b1;
        w_rd_addr_next = 6'd1;
      end
      S_WGT: begin
        g_bus_next = w_rd_data;
        widx_next  = widx + 7'd1;
        if (widx == 7'(WWORDS - 1)) begin
          state_next = S_INA;
          eidx_next  = 8'd0;
        end else if (widx == 7'(WWORDS - 2)) begin
          x_rd_en_next   = 1'b1;
          x_rd_addr_next = 8'd0;
        end else begin
          w_rd_en_next   = 1'b1;
          w_rd_addr_next = 6'(widx + 7'd2);
        end
      end
      S_INA: begin
        g_bus_next = x_rd_data[31:16];
        data_next  = x_rd_data[15:0];
        state_next = S_INB;
        if (({1'b0, eidx} + 9'd1) < {1'b0, nnz_q}) begin
          x_rd_en_next   = 1'b1;
          x_rd_addr_next = eidx + 8'd1;
        end
      end
      S_INB: begin
        g_bus_next = data_q;
        if (eidx == nnz_q - 8'd1) begin
          g_cmd_next = 1'b1;
          state_next = S_WOUT;
        end else begin
          eidx_next  = eidx + 8'd1;
          state_next = S_INA;
        end
      end
      S_WOUT: begin
        if (g_ostart) begin
          hdr_next   = g_bus_in;
          ridx_next  = 8'd0;
          state_next = S_CAP;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state_next = S_ERR;
        end
      end
      S_CAP: begin
        r_wr_en_next   = 1'b1;
        r_wr_addr_next = ridx;
        r_wr_data_next = g_bus_in;
        ridx_next      = ridx + 8'd1;
        if (ridx == 8'(OUT_WORDS - 1))
          state_next = g_rdy ? S_DONE : S_WEND;
      end
      S_WEND: begin
        if (g_rdy)
          state_next = S_DONE;
        else if (cnt == 16'(TIMEOUT - 1))
          state_next = S_ERR;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (state_next != state)
      cnt_next = 16'd0;

    busy_next = !(state_next inside {S_IDLE, S_DONE, S_ERR});
    done_next = (state_next == S_DONE);
    err_next  = (state_next == S_ERR) || reject;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      widx      <= 7'd0;
      eidx      <= 8'd0;
      ridx      <= 8'd0;
      col_q     <= 8'd0;
      nnz_q     <= 8'd0;
      data_q    <= 16'd0;
      hdr_col   <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      w_rd_en   <= 1'b0;
      w_rd_addr <= 6'd0;
      x_rd_en   <= 1'b0;
      x_rd_addr <= 8'd0;
      g_req     <= 1'b0;
      g_cmd     <= 1'b0;
      g_bus     <= 16'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 16'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      widx      <= widx_next;
      eidx      <= eidx_next;
      ridx      <= ridx_next;
      col_q     <= col_next;
      nnz_q     <= nnz_next;
      data_q    <= data_next;
      hdr_col   <= hdr_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
      w_rd_en   <= w_rd_en_next;
      w_rd_addr <= w_rd_addr_next;
      x_rd_en   <= x_rd_en_next;
      x_rd_addr <= x_rd_addr_next;
      g_req     <= g_req_next;
      g_cmd     <= g_cmd_next;
      g_bus     <= g_bus_next;
      r_wr_en   <= r_wr_en_next;
      r_wr_addr <= r_wr_addr_next;
      r_wr_data <= r_wr_data_next;
    end
  end

endmodule

// File: tb/tb_gcn_host_streamer.sv
// Scoreboard bench for gcn_host_streamer: RAM and accelerator models, expected frames
// built from RAM contents, and a monitor that checks the bus, result writes and job events.
module tb_gcn_host_streamer;
  localparam int WROWS = 32;
  localparam int OUT_WORDS = 200;
  localparam int TIMEOUT = 300;

  logic clk, rst, start;
  logic [7:0] col_base, nnz;
  logic busy, done, err;
  logic w_rd_en, x_rd_en;
  logic [5:0] w_rd_addr;
  logic [15:0] w_rd_data;
  logic [7:0] x_rd_addr;
  logic [31:0] x_rd_data;
  logic g_req, g_cmd;
  logic [15:0] g_bus;
  logic g_idle, g_ostart, g_rdy;
  logic [15:0] g_bus_in, hdr_col;
  logic r_wr_en;
  logic [7:0] r_wr_addr;
  logic [15:0] r_wr_data;

  gcn_host_streamer #(.WROWS(WROWS), .OUT_WORDS(OUT_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .col_base(col_base), .nnz(nnz),
    .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .g_req(g_req), .g_cmd(g_cmd), .g_bus(g_bus),
    .g_idle(g_idle), .g_ostart(g_ostart), .g_bus_in(g_bus_in), .g_rdy(g_rdy),
    .hdr_col(hdr_col), .r_wr_en(r_wr_en), .r_wr_addr(r_wr_addr), .r_wr_data(r_wr_data)
  );

  typedef struct {logic req; logic cmd; logic [15:0] bus;} bus_t;
  typedef struct {logic [7:0] addr; logic [15:0] data;} res_t;
  typedef struct {logic is_err; logic rel; int cyc;} evt_t;

  bus_t exp_bus[$];
  res_t exp_res[$];
  evt_t exp_evt[$];

  logic [15:0] wram [0:2*WROWS-1];
  logic [31:0] xram [0:255];
  logic [15:0] exp_hdr = 16'h0;
  int accel_mode = 0;
  int cyc = 0;
  int cmd_cycle = 0;
  int started = 0;
  int finished = 0;
  int errors = 0;
  int checks = 0;
  logic in_frame = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (w_rd_en) w_rd_data <= wram[w_rd_addr];
  always @(posedge clk) if (x_rd_en) x_rd_data <= xram[x_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accelerator model: answers each command frame with a header and OUT_WORDS results.
  initial begin
    logic [15:0] h;
    res_t r;
    g_ostart = 1'b0; g_bus_in = 16'h0; g_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_hdr = 16'h0;
      end else if (g_cmd && accel_mode != 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        h = 16'($urandom);
        g_ostart = 1'b1; g_bus_in = h; exp_hdr = h;
        for (int i = 0; i < OUT_WORDS; i++) begin
          @(negedge clk);
          g_ostart = 1'b0;
          r.addr = 8'(i); r.data = 16'($urandom);
          g_bus_in = r.data;
          exp_res.push_back(r);
          if (i == OUT_WORDS - 1 && accel_mode == 2) begin
            g_rdy = 1'b1;
            exp_evt.push_back('{1'b0, 1'b0, cyc + 1});
          end
        end
        @(negedge clk);
        g_rdy = 1'b0; g_bus_in = 16'h0;
        if (accel_mode != 2) begin
          repeat ($urandom_range(0, 8)) @(negedge clk);
          g_rdy = 1'b1;
          exp_evt.push_back('{1'b0, 1'b0, cyc + 1});
          @(negedge clk);
          g_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every observable transaction against the queued expectations.
  initial begin
    bus_t b;
    res_t r;
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_bus.delete(); exp_res.delete(); exp_evt.delete();
        in_frame = 1'b0;
        finished = started;
      end else begin
        if (g_req && !in_frame) begin
          in_frame = 1'b1;
          check("busy_in_frame", 32'(busy), 32'd1);
        end
        if (in_frame) begin
          if (exp_bus.size() == 0) begin
            check("bus_unexpected", {14'd0, g_req, g_cmd, g_bus}, 32'd0);
            in_frame = 1'b0;
          end else begin
            b = exp_bus.pop_front();
            check("bus_word", {14'd0, g_req, g_cmd, g_bus}, {14'd0, b.req, b.cmd, b.bus});
            if (b.cmd) in_frame = 1'b0;
          end
        end else begin
          check("bus_quiet", {14'd0, g_req, g_cmd, g_bus}, 32'd0);
        end
        if (g_cmd) cmd_cycle = cyc;
        if (r_wr_en) begin
          if (exp_res.size() == 0) begin
            check("result_unexpected", {8'd0, r_wr_addr, r_wr_data}, 32'd0);
          end else begin
            r = exp_res.pop_front();
            check("result_word", {8'd0, r_wr_addr, r_wr_data}, {8'd0, r.addr, r.data});
          end
        end
        if (done || err) begin
          if (exp_evt.size() == 0) begin
            check("event_unexpected", {30'd0, done, err}, 32'd0);
          end else begin
            e = exp_evt.pop_front();
            check("event_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
            check("event_cycle", cyc, e.rel ? cmd_cycle + e.cyc : e.cyc);
            check("event_busy", 32'(busy), 32'd0);
            check("hdr_col", 32'(hdr_col), 32'(exp_hdr));
            $display("job %0d: %s at cycle %0d hdr_col=%04h", finished, done ? "done" : "err", cyc, hdr_col);
          end
          finished++;
        end
      end
    end
  end

  task automatic start_job(input logic [7:0] col, input logic [7:0] n, input int mode);
    accel_mode = mode;
    for (int k = 0; k < 2 * WROWS; k++) wram[k] = 16'($urandom);
    for (int k = 0; k < 256; k++) xram[k] = $urandom;
    @(negedge clk);
    start = 1'b1; col_base = col; nnz = n;
    if (n == 8'd0) begin
      exp_evt.push_back('{1'b1, 1'b0, cyc + 1});
      started++;
    end else if (g_idle) begin
      exp_bus.push_back('{1'b1, 1'b0, 16'h0});
      exp_bus.push_back('{1'b0, 1'b0, {8'h00, col & 8'hFE}});
      for (int k = 0; k < 2 * WROWS; k++) exp_bus.push_back('{1'b0, 1'b0, wram[k]});
      for (int k = 0; k < int'(n); k++) begin
        exp_bus.push_back('{1'b0, 1'b0, xram[k][31:16]});
        exp_bus.push_back('{1'b0, k == int'(n) - 1, xram[k][15:0]});
      end
      if (mode == 1) exp_evt.push_back('{1'b1, 1'b1, TIMEOUT});
      started++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (finished != started && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("job_complete", 32'(finished), 32'(started));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sig(input int which);
    int n = 0;
    while (n < 2000 && !((which == 0) ? g_req : r_wr_en)) begin
      @(negedge clk);
      n++;
    end
    check(which == 0 ? "wait_g_req" : "wait_r_wr_en", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; col_base = 8'h0; nnz = 8'h0; g_idle = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {busy, done, err, w_rd_en, x_rd_en, g_req, g_cmd, r_wr_en, 8'd0, hdr_col}, 32'd0);

    start_job(8'd5, 8'd3, 0);
    wait_idle();
    start_job(8'h33, 8'd1, 0);
    wait_idle();
    start_job(8'd9, 8'd0, 0);
    wait_idle();

    g_idle = 1'b0;
    start_job(8'd12, 8'd4, 0);
    repeat (10) @(negedge clk);
    check("not_idle_ignored", 32'(busy), 32'd0);
    g_idle = 1'b1;
    start_job(8'd12, 8'd4, 0);
    wait_idle();

    start_job(8'd40, 8'd4, 1);
    wait_idle();

    start_job(8'd7, 8'd5, 0);
    wait_sig(0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_job", {busy, done, err, w_rd_en, x_rd_en, g_req, g_cmd, r_wr_en, g_bus, hdr_col}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_idle();
    start_job(8'd21, 8'd6, 0);
    wait_idle();

    start_job(8'd99, 8'd6, 2);
    wait_sig(1);
    @(negedge clk);
    start = 1'b1; nnz = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    for (int j = 0; j < 5; j++) begin
      start_job(8'($urandom), 8'($urandom_range(1, 24)), 0);
      wait_idle();
    end
    start_job(8'hFF, 8'd255, 0);
    wait_idle();

    check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    check("result_queue_drained", 32'(exp_res.size()), 32'd0);
    check("event_queue_drained", 32'(exp_evt.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
